// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write-destination/source select, optional write-to-read bypass and a bulk-clear engine.
// Latency: reads are combinational, writes commit at the next rising edge, and a clear occupies DEPTH-1 cycles.
// Backpressure: there is none; a write arriving while the clear engine is busy is dropped and flagged on wr_drop one cycle later.
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [1:0]               wr_sel,
  input  logic                     wr_src,
  input  logic [ADDR_W-1:0]        rt,
  input  logic [ADDR_W-1:0]        rd,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W-1:0]        pc,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} stateT;

  stateT              state, stateNext;
  logic [ADDR_W-1:0]  clrIdx;
  logic [DATA_W-1:0]  regs [DEPTH];
  logic [ADDR_W-1:0]  wrAddr;
  logic [DATA_W-1:0]  wrVal;
  logic               wrEff;
  logic               wrCommit;

  always_comb begin
    wrAddr = '0;
    case (wr_sel)
      2'b00:   wrAddr = LINK_IDX;
      2'b01:   wrAddr = rt;
      2'b10:   wrAddr = rd;
      default: wrAddr = '0;
    endcase
  end

  assign wrVal    = wr_src ? wr_data : pc + DATA_W'(4);
  assign wrEff    = wr_en && (wr_sel != 2'b11) && (wrAddr != '0);
  assign wrCommit = wrEff && (state == IDLE);
  assign busy     = (state == CLEAR);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (clr_req) stateNext = CLEAR;
      CLEAR:   if (clrIdx == LINK_IDX) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      clrIdx  <= ADDR_W'(1);
      wr_drop <= 1'b0;
    end else begin
      state   <= stateNext;
      wr_drop <= wrEff && (state == CLEAR);
      if (state == CLEAR)
        clrIdx <= (clrIdx == LINK_IDX) ? ADDR_W'(1) : clrIdx + ADDR_W'(1);
    end
  end

  // The clear engine and the write port never touch the array in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[clrIdx] <= '0;
    end else if (wrCommit) begin
      regs[wrAddr] <= wrVal;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*ADDR_W +: ADDR_W] == '0)
        rd_data[k*DATA_W +: DATA_W] = '0;
      else if (BYPASS && wrCommit && (rd_addr[k*ADDR_W +: ADDR_W] == wrAddr))
        rd_data[k*DATA_W +: DATA_W] = wrVal;
      else
        rd_data[k*DATA_W +: DATA_W] = regs[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one bypassing and one non-bypassing instance share all inputs.
module tb_reg_file_mp;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = 2'b11;
  logic        wr_src = 1'b0;
  logic [4:0]  rt = '0;
  logic [4:0]  rd = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] pc = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data, rdDataNb;
  logic        busy, busyNb, wr_drop, wrDropNb;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b1)) dut (
    .CLK(CLK), .RST(RST), .clr_req(clr_req), .busy(busy), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_src(wr_src), .rt(rt), .rd(rd), .wr_data(wr_data),
    .pc(pc), .rd_addr(rd_addr), .rd_data(rd_data), .wr_drop(wr_drop)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b0)) dutNb (
    .CLK(CLK), .RST(RST), .clr_req(clr_req), .busy(busyNb), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_src(wr_src), .rt(rt), .rd(rd), .wr_data(wr_data),
    .pc(pc), .rd_addr(rd_addr), .rd_data(rdDataNb), .wr_drop(wrDropNb)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic src, input logic [4:0] t,
                    input logic [4:0] d, input logic [31:0] data, input logic [31:0] p);
    wr_en = 1'b1; wr_sel = sel; wr_src = src; rt = t; rd = d; wr_data = data; pc = p;
    tick();
    wr_en = 1'b0; wr_sel = 2'b11;
  endtask

  function automatic logic [31:0] fillVal(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic fillAll();
    for (int i = 1; i < 32; i++) wr(2'b10, 1'b1, 5'd0, 5'(i), fillVal(i), 32'h0);
  endtask

  task automatic checkAllZero(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h0 || rd_data[63:32] !== 32'h0) begin
        errors++;
        $display("FAIL %s idx %0d: got %h/%h want 0", tag, a, rd_data[31:0], rd_data[63:32]);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) wr(2'b10, 1'b1, 5'd0, 5'(3 + i * 5), $urandom, 32'h0);
    wr_en = 1'b1; wr_sel = 2'b10; rd = 5'd4; wr_data = 32'hFFFF_FFFF; clr_req = 1'b1;
    RST = 1'b1;
    tick();
    RST = 1'b0; wr_en = 1'b0; wr_sel = 2'b11; clr_req = 1'b0;
    checks++;
    if (busy !== 1'b0 || wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b wr_drop=%b want 0/0", busy, wr_drop);
    end
    checkAllZero("reset_regs");
  endtask

  task automatic test_write_route();
    wr(2'b10, 1'b1, 5'd0, 5'd5, 32'hDEAD_BEEF, 32'h0);
    rd_addr = {5'd0, 5'd5}; #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL route_rd: got %h want deadbeef", rd_data[31:0]);
    end
    wr(2'b00, 1'b0, 5'd0, 5'd0, 32'h1111_1111, 32'h0040_0010);
    rd_addr = {5'd31, 5'd0}; #1;
    checks++;
    if (rd_data[63:32] !== 32'h0040_0014) begin
      errors++; $display("FAIL route_link: got %h want 00400014", rd_data[63:32]);
    end
    wr(2'b01, 1'b1, 5'd12, 5'd0, 32'hCAFE_0012, 32'h0);
    rd_addr = {5'd12, 5'd0}; #1;
    checks++;
    if (rd_data[63:32] !== 32'hCAFE_0012) begin
      errors++; $display("FAIL route_rt: got %h want cafe0012", rd_data[63:32]);
    end
    wr(2'b01, 1'b1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    rd_addr = {5'd0, 5'd0}; #1;
    checks++;
    if (rd_data !== 64'h0 || wr_drop !== 1'b0) begin
      errors++; $display("FAIL route_r0: got %h drop=%b want 0/0", rd_data, wr_drop);
    end
    wr(2'b11, 1'b1, 5'd5, 5'd5, 32'h0BAD_0BAD, 32'h0);
    rd_addr = {5'd5, 5'd5}; #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL route_nowrite: got %h want deadbeef", rd_data[31:0]);
    end
  endtask

  task automatic test_bypass();
    wr(2'b10, 1'b1, 5'd0, 5'd7, 32'h1111_1111, 32'h0);
    rd_addr = {5'd7, 5'd7};
    wr_en = 1'b1; wr_sel = 2'b10; wr_src = 1'b1; rd = 5'd7; wr_data = 32'h1234_5678;
    #1;
    checks++;
    if (rd_data !== {2{32'h1234_5678}}) begin
      errors++; $display("FAIL bypass_on: got %h want both 12345678", rd_data);
    end
    checks++;
    if (rdDataNb !== {2{32'h1111_1111}}) begin
      errors++; $display("FAIL bypass_off_old: got %h want both 11111111", rdDataNb);
    end
    tick();
    wr_en = 1'b0; wr_sel = 2'b11; #1;
    checks++;
    if (rdDataNb !== {2{32'h1234_5678}}) begin
      errors++; $display("FAIL bypass_off_new: got %h want both 12345678", rdDataNb);
    end
  endtask

  task automatic test_wrap();
    wr(2'b00, 1'b0, 5'd0, 5'd0, 32'h5555_5555, 32'hFFFF_FFFC);
    rd_addr = {5'd31, 5'd31}; #1;
    checks++;
    if (rd_data[31:0] !== 32'h0) begin
      errors++; $display("FAIL wrap: got %h want 00000000", rd_data[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    wr(2'b10, 1'b1, 5'd0, 5'd1, 32'h0000_0101, 32'h0);
    wr(2'b01, 1'b1, 5'd2, 5'd0, 32'h0000_0202, 32'h0);
    wr(2'b10, 1'b0, 5'd0, 5'd3, 32'h0, 32'h0000_1000);
    rd_addr = {5'd2, 5'd1}; #1;
    checks++;
    if (rd_data !== {32'h0000_0202, 32'h0000_0101}) begin
      errors++; $display("FAIL b2b_12: got %h want 00000202_00000101", rd_data);
    end
    rd_addr = {5'd3, 5'd3}; #1;
    checks++;
    if (rd_data !== {2{32'h0000_1004}}) begin
      errors++; $display("FAIL b2b_3: got %h want both 00001004", rd_data);
    end
  endtask

  task automatic test_clear();
    int cnt;
    fillAll();
    rd_addr = {5'd20, 5'd9};
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    for (int g = 0; g < 40; g++) begin
      if (busy !== 1'b1) break;
      cnt++;
      if (cnt == 3) begin
        wr_en = 1'b1; wr_sel = 2'b10; wr_src = 1'b1; rd = 5'd9; wr_data = 32'h0BAD_F00D;
        #1;
        checks++;
        if (rd_data[31:0] !== fillVal(9)) begin
          errors++; $display("FAIL clear_nobypass: got %h want %h", rd_data[31:0], fillVal(9));
        end
      end else if (cnt == 4) begin
        wr_en = 1'b0; wr_sel = 2'b11;
        checks++;
        if (wr_drop !== 1'b1) begin
          errors++; $display("FAIL clear_drop: got %b want 1", wr_drop);
        end
      end else if (cnt == 5) begin
        clr_req = 1'b1;
        checks++;
        if (wr_drop !== 1'b0) begin
          errors++; $display("FAIL clear_drop_end: got %b want 0", wr_drop);
        end
      end else if (cnt == 6) begin
        clr_req = 1'b0;
        checks++;
        if (rd_data[63:32] !== fillVal(20)) begin
          errors++; $display("FAIL clear_partial: got %h want %h", rd_data[63:32], fillVal(20));
        end
      end
      tick();
    end
    checks++;
    if (cnt != 31) begin
      errors++; $display("FAIL clear_len: got %0d cycles want 31", cnt);
    end
    checks++;
    if (busyNb !== 1'b0 || wr_drop !== 1'b0) begin
      errors++; $display("FAIL clear_idle: busyNb=%b drop=%b want 0/0", busyNb, wr_drop);
    end
    checkAllZero("clear_regs");
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    fillAll();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL midrst_busy: got %b want 0", busy);
    end
    checkAllZero("midrst_regs");
    wr(2'b10, 1'b1, 5'd0, 5'd30, 32'h7777_7777, 32'h0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    for (int g = 0; g < 40; g++) begin
      if (busy !== 1'b1) break;
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 31) begin
      errors++; $display("FAIL midrst_len: got %0d cycles want 31", cnt);
    end
    rd_addr = {5'd30, 5'd30}; #1;
    checks++;
    if (rd_data !== 64'h0) begin
      errors++; $display("FAIL midrst_r30: got %h want 0", rd_data);
    end
  endtask

  initial begin
    tick();
    RST = 1'b0;
    test_reset();
    test_write_route();
    test_bypass();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
